// File: rtl/updn_ctr_dcnto_mode_pkg.sv
// Shared types and constants for the up/down count-to counter with run modes.
package updn_ctr_dcnto_mode_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP   = 2'b00,
        MODE_STOP   = 2'b01,
        MODE_RELOAD = 2'b10,
        MODE_BOUNCE = 2'b11
    } mode_e;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/updn_ctr_dcnto_mode_if.sv
// Control/status bundle of the mode counter; master drives controls, slave is the counter.
interface updn_ctr_dcnto_mode_if #(
    parameter int unsigned WIDTH = 4
);
    import updn_ctr_dcnto_mode_pkg::*;

    logic             load;
    logic             cen;
    logic             up_dn;
    mode_e            mode;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] count_to;
    logic [WIDTH-1:0] count;
    logic             tercnt;
    logic             tc_pulse;
    logic             wrap;
    logic             dir;
    logic             halted;

    modport master (
        output load, cen, up_dn, mode, data, count_to,
        input  count, tercnt, tc_pulse, wrap, dir, halted
    );

    modport slave (
        input  load, cen, up_dn, mode, data, count_to,
        output count, tercnt, tc_pulse, wrap, dir, halted
    );

endinterface

// File: rtl/updn_ctr_dcnto_mode_step.sv
// Combinational count +/- STEP modulo 2**WIDTH; carry flags overflow or underflow.
module updn_ctr_dcnto_mode_step #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned STEP  = 1
) (
    input  logic [WIDTH-1:0] cur,
    input  logic             up,
    output logic [WIDTH-1:0] nxt,
    output logic             carry
);
    localparam logic [WIDTH:0] STEP_X = {1'b0, WIDTH'(STEP)};

    logic [WIDTH:0] sum;

    // Extra MSB captures carry on add and borrow on subtract.
    always_comb begin
        sum = up ? ({1'b0, cur} + STEP_X) : ({1'b0, cur} - STEP_X);
    end

    assign nxt   = sum[WIDTH-1:0];
    assign carry = sum[WIDTH];

endmodule

// File: rtl/updn_ctr_dcnto_mode.sv
// Up/down counter with live count-to compare and WRAP/STOP/RELOAD/BOUNCE run modes.
module updn_ctr_dcnto_mode
    import updn_ctr_dcnto_mode_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned STEP  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    updn_ctr_dcnto_mode_if.slave  bus
);
    logic [WIDTH-1:0] count_q, count_d;
    logic             dir_q, dir_d;
    logic             halted_q, halted_d;
    logic             tc_q, tc_d;
    logic             wrap_q, wrap_d;

    logic             match;
    logic             step_up;
    logic [WIDTH-1:0] step_val;
    logic             step_carry;

    assign match = (count_q == bus.count_to);

    // BOUNCE steers by the stored direction and reverses at the bounds.
    always_comb begin
        step_up = bus.up_dn;
        if (bus.mode == MODE_BOUNCE) begin
            if (dir_q && match)                   step_up = DIR_DN;
            else if (!dir_q && count_q == bus.data) step_up = DIR_UP;
            else                                  step_up = dir_q;
        end
    end

    updn_ctr_dcnto_mode_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .cur   (count_q),
        .up    (step_up),
        .nxt   (step_val),
        .carry (step_carry)
    );

    always_comb begin
        count_d  = count_q;
        dir_d    = dir_q;
        halted_d = halted_q;
        tc_d     = 1'b0;
        wrap_d   = 1'b0;
        if (!bus.load) begin
            count_d  = bus.data;
            dir_d    = bus.up_dn;
            halted_d = 1'b0;
        end else if (bus.cen && !halted_q) begin
            // Plain step first; mode-specific target handling overrides it.
            count_d = step_val;
            wrap_d  = step_carry;
            dir_d   = step_up;
            tc_d    = match;
            case (bus.mode)
                MODE_STOP: begin
                    if (match) begin
                        count_d  = count_q;
                        wrap_d   = 1'b0;
                        halted_d = 1'b1;
                    end
                end
                MODE_RELOAD: begin
                    if (match) begin
                        count_d = bus.data;
                        wrap_d  = 1'b0;
                    end
                end
                MODE_BOUNCE: begin
                    // Degenerate range: park on the single value.
                    if (match && bus.data == bus.count_to) begin
                        count_d = count_q;
                        wrap_d  = 1'b0;
                        dir_d   = dir_q;
                    end
                end
                MODE_WRAP: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q  <= '0;
            dir_q    <= DIR_UP;
            halted_q <= 1'b0;
            tc_q     <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            count_q  <= count_d;
            dir_q    <= dir_d;
            halted_q <= halted_d;
            tc_q     <= tc_d;
            wrap_q   <= wrap_d;
        end
    end

    assign bus.count    = count_q;
    assign bus.tercnt   = match;
    assign bus.tc_pulse = tc_q;
    assign bus.wrap     = wrap_q;
    assign bus.dir      = dir_q;
    assign bus.halted   = halted_q;

endmodule

// File: tb/tb_updn_ctr_dcnto_mode.sv
// Randomised and directed bench for the mode counter, STEP=1 and STEP=3 instances.
module tb_updn_ctr_dcnto_mode;
    import updn_ctr_dcnto_mode_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       load, cen, up_dn;
    mode_e      mode;
    logic [3:0] data, count_to;

    int vectors     = 0;
    int miscompares = 0;

    int   stp [2] = '{1, 3};
    int   m_cnt [2];
    logic m_dir [2];
    logic m_halt [2];
    logic m_tc [2];
    logic m_wr [2];

    always #5 clk = ~clk;

    updn_ctr_dcnto_mode_if #(.WIDTH(4)) b0 ();
    updn_ctr_dcnto_mode_if #(.WIDTH(4)) b1 ();

    assign b0.load = load;   assign b1.load = load;
    assign b0.cen = cen;     assign b1.cen = cen;
    assign b0.up_dn = up_dn; assign b1.up_dn = up_dn;
    assign b0.mode = mode;   assign b1.mode = mode;
    assign b0.data = data;   assign b1.data = data;
    assign b0.count_to = count_to; assign b1.count_to = count_to;

    updn_ctr_dcnto_mode #(.WIDTH(4), .STEP(1)) dut0 (.clk(clk), .reset(reset), .bus(b0));
    updn_ctr_dcnto_mode #(.WIDTH(4), .STEP(3)) dut1 (.clk(clk), .reset(reset), .bus(b1));

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_dir[k] = 1'b1; m_halt[k] = 1'b0; m_tc[k] = 1'b0; m_wr[k] = 1'b0;
        end
    endtask

    // Reference behaviour from the mode rules, in integer arithmetic.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            int   v;
            logic go_up;
            logic hit;
            logic moves;
            hit = (m_cnt[k] == int'(count_to));
            m_tc[k] = 1'b0;
            m_wr[k] = 1'b0;
            moves = 1'b0;
            go_up = up_dn;
            if (!load) begin
                m_cnt[k] = int'(data); m_dir[k] = up_dn; m_halt[k] = 1'b0;
            end else if (cen && !m_halt[k]) begin
                if (mode == MODE_BOUNCE) begin
                    if (hit && data == count_to) m_tc[k] = 1'b1;
                    else begin
                        go_up = m_dir[k];
                        if (m_dir[k] && hit) go_up = 1'b0;
                        else if (!m_dir[k] && m_cnt[k] == int'(data)) go_up = 1'b1;
                        m_tc[k] = hit;
                        moves = 1'b1;
                    end
                end else begin
                    m_dir[k] = up_dn;
                    if (hit && mode == MODE_STOP) begin
                        m_halt[k] = 1'b1; m_tc[k] = 1'b1;
                    end else if (hit && mode == MODE_RELOAD) begin
                        m_cnt[k] = int'(data); m_tc[k] = 1'b1;
                    end else begin
                        m_tc[k] = hit;
                        moves = 1'b1;
                    end
                end
                if (moves) begin
                    v = go_up ? m_cnt[k] + stp[k] : m_cnt[k] - stp[k];
                    m_wr[k]  = (v > 15) || (v < 0);
                    m_cnt[k] = v & 15;
                    m_dir[k] = go_up;
                end
            end
        end
    endtask

    task automatic apply(input logic ld, input logic ce, input logic ud, input mode_e md,
                         input logic [3:0] d, input logic [3:0] ct);
        load = ld; cen = ce; up_dn = ud; mode = md; data = d; count_to = ct;
        model_edge();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] obs(input int k);
        if (k == 0) return {b0.count, b0.tc_pulse, b0.wrap, b0.dir, b0.halted, b0.tercnt};
        return {b1.count, b1.tc_pulse, b1.wrap, b1.dir, b1.halted, b1.tercnt};
    endfunction

    function automatic logic [8:0] expv(input int k);
        return {4'(m_cnt[k]), m_tc[k], m_wr[k], m_dir[k], m_halt[k], (m_cnt[k] == int'(count_to))};
    endfunction

    task automatic test_reset();
        reset = 1'b1; load = 1'b1; cen = 1'b0; up_dn = 1'b1; mode = MODE_WRAP;
        data = 4'd0; count_to = 4'd0;
        model_reset();
        #12;
        vectors++;
        if (obs(0) !== 9'b0000_0_0_1_0_1) begin
            miscompares++;
            $display("FAIL reset_state: dut=%h expected=%h", obs(0), 9'b0000_0_0_1_0_1);
        end
        reset = 1'b0;
        apply(1'b1, 1'b0, 1'b1, MODE_WRAP, 4'd3, 4'd9);
        vectors++;
        if (obs(0) !== expv(0)) begin
            miscompares++;
            $display("FAIL reset_hold: dut=%h model=%h", obs(0), expv(0));
        end
    endtask

    task automatic test_wrap();
        apply(1'b0, 1'b1, 1'b1, MODE_WRAP, 4'd0, 4'd8);
        for (int i = 0; i < 16; i++) begin
            apply(1'b1, 1'b1, 1'b1, MODE_WRAP, 4'd0, 4'd8);
            vectors++;
            if (obs(0) !== expv(0)) begin
                miscompares++;
                $display("FAIL wrap_up cyc %0d: dut=%h model=%h", i, obs(0), expv(0));
            end
            if (i == 7) begin
                vectors++;
                if (b0.tercnt !== 1'b1) begin
                    miscompares++;
                    $display("FAIL wrap_tercnt: got %b expected 1", b0.tercnt);
                end
            end
            if (i == 8) begin
                vectors++;
                if (b0.tc_pulse !== 1'b1 || b0.count !== 4'd9) begin
                    miscompares++;
                    $display("FAIL wrap_tc: tc=%b count=%0d expected tc=1 count=9", b0.tc_pulse, b0.count);
                end
            end
        end
        vectors++;
        if (b0.count !== 4'd0 || b0.wrap !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_rollover: count=%0d wrap=%b expected 0 1", b0.count, b0.wrap);
        end
    endtask

    task automatic test_stop();
        apply(1'b0, 1'b1, 1'b1, MODE_STOP, 4'd0, 4'd4);
        for (int i = 0; i < 7; i++) begin
            apply(1'b1, 1'b1, 1'b1, MODE_STOP, 4'd0, 4'd4);
            vectors++;
            if (obs(0) !== expv(0)) begin
                miscompares++;
                $display("FAIL stop cyc %0d: dut=%h model=%h", i, obs(0), expv(0));
            end
        end
        vectors++;
        if (b0.count !== 4'd4 || b0.halted !== 1'b1) begin
            miscompares++;
            $display("FAIL stop_halt: count=%0d halted=%b expected 4 1", b0.count, b0.halted);
        end
        apply(1'b0, 1'b1, 1'b1, MODE_STOP, 4'd2, 4'd4);
        vectors++;
        if (b0.count !== 4'd2 || b0.halted !== 1'b0) begin
            miscompares++;
            $display("FAIL stop_reload: count=%0d halted=%b expected 2 0", b0.count, b0.halted);
        end
    endtask

    task automatic test_reload();
        apply(1'b0, 1'b1, 1'b1, MODE_RELOAD, 4'd2, 4'd5);
        for (int i = 0; i < 16; i++) begin
            logic [3:0] ct;
            ct = (i < 10) ? 4'd5 : 4'd3;
            apply(1'b1, 1'b1, 1'b1, MODE_RELOAD, 4'd2, ct);
            vectors++;
            if (obs(0) !== expv(0)) begin
                miscompares++;
                $display("FAIL reload cyc %0d: dut=%h model=%h", i, obs(0), expv(0));
            end
            if (i == 3) begin
                vectors++;
                if (b0.count !== 4'd2 || b0.tc_pulse !== 1'b1) begin
                    miscompares++;
                    $display("FAIL reload_period: count=%0d tc=%b expected 2 1", b0.count, b0.tc_pulse);
                end
            end
        end
    endtask

    task automatic test_bounce();
        apply(1'b0, 1'b1, 1'b1, MODE_BOUNCE, 4'd1, 4'd6);
        for (int i = 0; i < 20; i++) begin
            apply(1'b1, 1'b1, 1'($urandom_range(0, 1)), MODE_BOUNCE, 4'd1, 4'd6);
            vectors++;
            if (obs(0) !== expv(0)) begin
                miscompares++;
                $display("FAIL bounce cyc %0d: dut=%h model=%h", i, obs(0), expv(0));
            end
            if (i == 5) begin
                vectors++;
                if (b0.count !== 4'd5 || b0.dir !== 1'b0 || b0.tc_pulse !== 1'b1) begin
                    miscompares++;
                    $display("FAIL bounce_top: count=%0d dir=%b tc=%b expected 5 0 1", b0.count, b0.dir, b0.tc_pulse);
                end
            end
            if (i == 10) begin
                vectors++;
                if (b0.count !== 4'd2 || b0.dir !== 1'b1) begin
                    miscompares++;
                    $display("FAIL bounce_bottom: count=%0d dir=%b expected 2 1", b0.count, b0.dir);
                end
            end
        end
    endtask

    task automatic test_down_and_step3();
        apply(1'b0, 1'b1, 1'b0, MODE_WRAP, 4'd0, 4'd4);
        apply(1'b1, 1'b1, 1'b0, MODE_WRAP, 4'd0, 4'd4);
        vectors++;
        if (b0.count !== 4'd15 || b0.wrap !== 1'b1) begin
            miscompares++;
            $display("FAIL down_underflow: count=%0d wrap=%b expected 15 1", b0.count, b0.wrap);
        end
        apply(1'b1, 1'b1, 1'b0, MODE_WRAP, 4'd0, 4'd4);
        vectors++;
        if (obs(0) !== expv(0)) begin
            miscompares++;
            $display("FAIL down_step: dut=%h model=%h", obs(0), expv(0));
        end
        apply(1'b0, 1'b1, 1'b0, MODE_WRAP, 4'd7, 4'd4);
        vectors++;
        if (b0.count !== 4'd7 || b1.count !== 4'd7) begin
            miscompares++;
            $display("FAIL load_over_cen: count0=%0d count1=%0d expected 7", b0.count, b1.count);
        end
        apply(1'b0, 1'b1, 1'b1, MODE_WRAP, 4'd0, 4'd4);
        for (int i = 0; i < 8; i++) begin
            apply(1'b1, 1'b1, 1'b1, MODE_WRAP, 4'd0, 4'd4);
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (obs(k) !== expv(k)) begin
                    miscompares++;
                    $display("FAIL step3 dut%0d cyc %0d: dut=%h model=%h", k, i, obs(k), expv(k));
                end
            end
            vectors++;
            if (b1.tc_pulse !== 1'b0) begin
                miscompares++;
                $display("FAIL step3_skip cyc %0d: tc=%b expected 0", i, b1.tc_pulse);
            end
        end
    endtask

    task automatic test_async_reset();
        apply(1'b0, 1'b1, 1'b1, MODE_STOP, 4'd0, 4'd2);
        for (int i = 0; i < 4; i++) apply(1'b1, 1'b1, 1'b1, MODE_STOP, 4'd0, 4'd2);
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        vectors++;
        if (b0.count !== 4'd0 || b0.halted !== 1'b0 || b0.dir !== 1'b1) begin
            miscompares++;
            $display("FAIL async_reset: count=%0d halted=%b dir=%b expected 0 0 1", b0.count, b0.halted, b0.dir);
        end
        @(posedge clk);
        #3;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            apply(1'b1, 1'b1, 1'b1, MODE_WRAP, 4'd0, 4'd2);
            vectors++;
            if (obs(0) !== expv(0)) begin
                miscompares++;
                $display("FAIL reset_resume cyc %0d: dut=%h model=%h", i, obs(0), expv(0));
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] ct;
        ct = 4'd9;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) ct = 4'($urandom_range(0, 15));
            apply(($urandom_range(0, 15) != 0), ($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), mode_e'(2'($urandom_range(0, 3))),
                  4'($urandom_range(0, 15)), ct);
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (obs(k) !== expv(k)) begin
                    miscompares++;
                    $display("FAIL random dut%0d cyc %0d: dut=%h model=%h", k, i, obs(k), expv(k));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_stop();
        test_reload();
        test_bounce();
        test_down_and_step3();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
